// File: rtl/cmd_arbiter_if.sv
// rtl/cmd_arbiter_if.sv - request, command and status signals of cmd_arbiter
interface cmd_arbiter_if;
    logic [7:0] req0_cmd;
    logic       req0_vld;
    logic       req0_ack;
    logic [7:0] req1_cmd;
    logic       req1_vld;
    logic       req1_ack;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic       src;
    logic       timeout;

    modport master (
        input  req0_cmd, req0_vld, req1_cmd, req1_vld, clr_cmd_rdy,
        output req0_ack, req1_ack, cmd, cmd_rdy, src, timeout
    );

    modport slave (
        output req0_cmd, req0_vld, req1_cmd, req1_vld, clr_cmd_rdy,
        input  req0_ack, req1_ack, cmd, cmd_rdy, src, timeout
    );
endinterface

// File: rtl/cmd_arbiter.sv
// rtl/cmd_arbiter.sv - two-source command arbiter, round-robin with STOP priority and watchdog
module cmd_arbiter #(
    parameter  int TO_CYCLES = 50000,
    localparam int CNT_W     = $clog2(TO_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    cmd_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, PRESENT, ACK} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       cmd_nxt;
    logic             src_nxt;
    logic             rr_ptr, rr_nxt;
    logic             to_flag, to_nxt;
    logic             gnt_sel;
    logic             stop0, stop1;

    assign stop0 = (bus.req0_cmd[7:6] == 2'b00);
    assign stop1 = (bus.req1_cmd[7:6] == 2'b00);

    // A lone requester wins outright; a lone STOP wins a contest; otherwise take turns.
    always_comb begin
        gnt_sel = rr_ptr;
        if (bus.req0_vld != bus.req1_vld) begin
            gnt_sel = bus.req1_vld;
        end else if (stop0 != stop1) begin
            gnt_sel = stop1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cmd_nxt   = bus.cmd;
        src_nxt   = bus.src;
        rr_nxt    = rr_ptr;
        to_nxt    = to_flag;
        unique case (state)
            IDLE: begin
                if (bus.req0_vld || bus.req1_vld) begin
                    state_nxt = PRESENT;
                    cmd_nxt   = gnt_sel ? bus.req1_cmd : bus.req0_cmd;
                    src_nxt   = gnt_sel;
                    cnt_nxt   = '0;
                end
            end
            PRESENT: begin
                if (bus.clr_cmd_rdy) begin
                    state_nxt = ACK;
                    to_nxt    = 1'b0;
                end else if (cnt == CNT_W'(TO_CYCLES - 1)) begin
                    state_nxt = ACK;
                    to_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ACK: begin
                state_nxt = IDLE;
                rr_nxt    = ~bus.src;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every one of them leaves a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rr_ptr       <= 1'b0;
            to_flag      <= 1'b0;
            bus.cmd      <= 8'h00;
            bus.src      <= 1'b0;
            bus.cmd_rdy  <= 1'b0;
            bus.req0_ack <= 1'b0;
            bus.req1_ack <= 1'b0;
            bus.timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rr_ptr       <= rr_nxt;
            to_flag      <= to_nxt;
            bus.cmd      <= cmd_nxt;
            bus.src      <= src_nxt;
            bus.cmd_rdy  <= (state_nxt == PRESENT);
            bus.req0_ack <= (state_nxt == ACK) && !src_nxt;
            bus.req1_ack <= (state_nxt == ACK) && src_nxt;
            bus.timeout  <= (state_nxt == ACK) && to_nxt;
        end
    end
endmodule
